// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state type, sizing helper and default golden table for truth_table_sweeper
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // f = x & (~y | ~w | ~z), bit i holds f at vec == i
  localparam logic [15:0] DEFAULT_GOLDEN = 16'h7F00;

  function automatic int num_vec(input int num_in);
    return 2 ** num_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_impl_compare.sv
// rtl/truth_table_sweeper_impl_compare.sv - flags any implementation output differing from the reference copy impl_in[0]
module impl_compare #(
  parameter int NUM_IMPL = 4
) (
  input  logic [NUM_IMPL-1:0] impl_in,
  output logic                any_mismatch
);

  assign any_mismatch = |(impl_in ^ {NUM_IMPL{impl_in[0]}});

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors, captures the truth table and flags disagreeing minterms
// Optional golden-table comparison enabled by TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                    NUM_IN   = 4,
  parameter int                    NUM_IMPL = 4,
  parameter int                    SETTLE   = 1,
  parameter logic [2**NUM_IN-1:0]  GOLDEN   = DEFAULT_GOLDEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_IMPL-1:0]   impl_in,
  output logic [NUM_IN-1:0]     vec_out,
  output logic                  busy,
  output logic                  done,
  output logic [2**NUM_IN-1:0]  table_out,
  output logic [2**NUM_IN-1:0]  mismatch_mask,
  output logic [NUM_IN:0]       mismatch_cnt,
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
  output logic [2**NUM_IN-1:0]  golden_err_mask,
`endif
  output logic                  pass
);

  localparam int                NUM_VEC     = num_vec(NUM_IN);
  localparam int                SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [NUM_IN-1:0] VEC_LAST    = '1;
  localparam logic [NUM_IN-1:0] VEC_ONE     = NUM_IN'(1);
  localparam logic [NUM_IN:0]   CNT_ONE     = (NUM_IN + 1)'(1);

  sweep_state_t         state_q, state_d;
  logic [NUM_IN-1:0]    vec_q, vec_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [NUM_VEC-1:0]   table_q, table_d;
  logic [NUM_VEC-1:0]   mask_q, mask_d;
  logic [NUM_IN:0]      cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 any_mismatch;

`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
  logic [NUM_VEC-1:0]   err_q, err_d;
`else
  logic                 unused_golden;
  assign unused_golden = ^GOLDEN;
`endif

  impl_compare #(
    .NUM_IMPL (NUM_IMPL)
  ) u_impl_compare (
    .impl_in      (impl_in),
    .any_mismatch (any_mismatch)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    table_d  = table_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A restart from DONE behaves exactly like a start from IDLE
        if (start) begin
          table_d  = '0;
          mask_d   = '0;
          cnt_d    = '0;
          pass_d   = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
          err_d    = '0;
`endif
          vec_d    = '0;
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_SAMPLE: begin
        table_d[vec_q] = impl_in[0];
        if (any_mismatch) begin
          mask_d[vec_q] = 1'b1;
          cnt_d         = cnt_q + CNT_ONE;
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
          pass_d  = (cnt_d == '0) && (table_d == GOLDEN);
          err_d   = table_d ^ GOLDEN;
`else
          pass_d  = (cnt_d == '0);
`endif
        end else begin
          vec_d    = vec_q + VEC_ONE;
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign vec_out       = vec_q;
  assign busy          = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done          = (state_q == ST_DONE);
  assign table_out     = table_q;
  assign mismatch_mask = mask_q;
  assign mismatch_cnt  = cnt_q;
  assign pass          = pass_q;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
  assign golden_err_mask = err_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed bench with expected-result scoreboard for truth_table_sweeper
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic [15:0] mask;
    logic [4:0]  cnt;
    logic        pass;
    logic [15:0] err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  impl_in;
  logic [3:0]  vec_out;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [15:0] mismatch_mask;
  logic [4:0]  mismatch_cnt;
  logic        pass;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
  logic [15:0] golden_err_mask;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;
  exp_t sb_q[$];

  truth_table_sweeper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .impl_in       (impl_in),
    .vec_out       (vec_out),
    .busy          (busy),
    .done          (done),
    .table_out     (table_out),
    .mismatch_mask (mismatch_mask),
    .mismatch_cnt  (mismatch_cnt),
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    .golden_err_mask (golden_err_mask),
`endif
    .pass          (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: all correct, 1: impl 3 stuck at 0, 2: all compute x&y
  function automatic logic [3:0] model_impl(input int m, input logic [3:0] v);
    logic x, y, w, z, f;
    x = v[3]; y = v[2]; w = v[1]; z = v[0];
    f = x & (~y | ~w | ~z);
    case (m)
      1:       return {1'b0, f, f, f};
      2:       return {4{x & y}};
      default: return {4{f}};
    endcase
  endfunction

  always_comb impl_in = model_impl(mode, vec_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int m);
    exp_t       e;
    logic [3:0] r;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      r = model_impl(m, 4'(i));
      e.tbl[i] = r[0];
      if (r != {4{r[0]}}) begin
        e.mask[i] = 1'b1;
        e.cnt     = e.cnt + 5'd1;
      end
    end
    e.err  = e.tbl ^ 16'h7F00;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    e.pass = (e.cnt == 5'd0) && (e.tbl == 16'h7F00);
`else
    e.pass = (e.cnt == 5'd0);
`endif
    sb_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec"},  vec_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tbl"},  table_out, 0);
    chk({tag, "_mask"}, mismatch_mask, 0);
    chk({tag, "_cnt"},  mismatch_cnt, 0);
    chk({tag, "_pass"}, pass, 0);
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    chk({tag, "_err"},  golden_err_mask, 0);
`endif
  endtask

  task automatic run_sweep(input string tag, input int m, input bit poke, input bit rst15);
    int   n;
    bit   got_done;
    exp_t e;
    mode = m;
    push_expected(m);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_start_done"}, done, 0);
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_tbl"},  table_out, 0);
    chk({tag, "_start_cnt"},  mismatch_cnt, 0);
    n = 0;
    got_done = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) n++;
        start = (poke && n == 10);
        if (rst15 && n == 15) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check_zero({tag, "_midrst"});
          void'(sb_q.pop_front());
          repeat (3) @(negedge clk);
          chk({tag, "_midrst_idle"}, busy, 0);
          return;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_busy_cycles"}, n, 32);
    chk({tag, "_vec_last"}, vec_out, 4'hF);
    e = sb_q.pop_front();
    chk({tag, "_tbl"},  table_out, e.tbl);
    chk({tag, "_mask"}, mismatch_mask, e.mask);
    chk({tag, "_cnt"},  mismatch_cnt, e.cnt);
    chk({tag, "_pass"}, pass, e.pass);
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    chk({tag, "_err"},  golden_err_mask, e.err);
`endif
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, done, 1);
    chk({tag, "_tbl_held"},  table_out, e.tbl);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("idle");

    run_sweep("clean", 0, 1'b0, 1'b0);
    run_sweep("fault", 1, 1'b0, 1'b0);
    run_sweep("busy_start", 0, 1'b1, 1'b0);
    run_sweep("rst_mid", 0, 1'b0, 1'b1);
    run_sweep("after_rst", 0, 1'b0, 1'b0);
    run_sweep("xy_restart", 2, 1'b0, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
